// File: rtl/midi_note_parser.sv
// rtl/midi_note_parser.sv - MIDI channel-voice byte parser driving a monophonic note index, gate and velocity
module midi_note_parser #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic       inCLK,
    input  logic       inRST,
    input  logic [7:0] inByte,
    input  logic       inByteValid,
    output logic [6:0] outMidiFrequencyIndex,
    output logic       outGate,
    output logic [6:0] outVelocity,
    output logic       outNoteEvent
);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_DATA1, S_DATA2} state_t;

    localparam logic [3:0] LP_CHANNEL = 4'(CHANNEL);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_status;
    logic       r_match;
    logic [6:0] r_d1;
    logic [6:0] r_index;
    logic       r_gate;
    logic [6:0] r_velocity;
    logic       r_event;

    logic       w_is_realtime;
    logic       w_is_system;
    logic       w_is_channel;
    logic       w_is_data;
    logic       w_one_data;
    logic       w_complete;
    logic [6:0] w_msg_d1;
    logic [6:0] w_msg_d2;
    logic [6:0] w_index_next;
    logic       w_gate_next;
    logic [6:0] w_velocity_next;
    logic       w_event_next;

    assign w_is_realtime = inByteValid && (inByte[7:3] == 5'b11111);
    assign w_is_system   = inByteValid && (inByte[7:3] == 5'b11110);
    assign w_is_channel  = inByteValid && inByte[7] && (inByte[7:4] != 4'hF);
    assign w_is_data     = inByteValid && !inByte[7];
    assign w_one_data    = (r_status == 4'hC) || (r_status == 4'hD);

    // A message completes on its last data byte; single-byte messages finish in S_DATA1.
    assign w_complete = w_is_data &&
                        (((r_state == S_DATA1) && w_one_data) || (r_state == S_DATA2));
    assign w_msg_d1   = (r_state == S_DATA1) ? inByte[6:0] : r_d1;
    assign w_msg_d2   = inByte[6:0];

    always_ff @(posedge inCLK) begin
        if (inRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_is_system) begin
            w_state_next = (inByte == 8'hF0) ? S_SKIP : S_IDLE;
        end else if (w_is_channel) begin
            w_state_next = S_DATA1;
        end else if (w_is_data) begin
            case (r_state)
                S_DATA1: w_state_next = w_one_data ? S_DATA1 : S_DATA2;
                S_DATA2: w_state_next = S_DATA1;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_index_next    = r_index;
        w_gate_next     = r_gate;
        w_velocity_next = r_velocity;
        w_event_next    = 1'b0;
        if (w_complete && r_match) begin
            if ((r_status == 4'h9) && (w_msg_d2 != 7'd0)) begin
                w_index_next    = w_msg_d1;
                w_velocity_next = w_msg_d2;
                w_gate_next     = 1'b1;
                w_event_next    = 1'b1;
            end else if ((r_status == 4'h8) || (r_status == 4'h9)) begin
                // Release keeps pitch and velocity; only the held note can release.
                if (r_gate && (w_msg_d1 == r_index)) begin
                    w_gate_next  = 1'b0;
                    w_event_next = 1'b1;
                end
            end else if ((r_status == 4'hB) && (w_msg_d1 == 7'd123)) begin
                w_gate_next  = 1'b0;
                w_event_next = 1'b1;
            end
        end
    end

    always_ff @(posedge inCLK) begin
        if (inRST) begin
            r_status   <= 4'h0;
            r_match    <= 1'b0;
            r_d1       <= 7'd0;
            r_index    <= 7'd0;
            r_gate     <= 1'b0;
            r_velocity <= 7'd0;
            r_event    <= 1'b0;
        end else begin
            if (w_is_channel) begin
                r_status <= inByte[7:4];
                r_match  <= OMNI || (inByte[3:0] == LP_CHANNEL);
            end else if (w_is_system) begin
                r_status <= 4'h0;
                r_match  <= 1'b0;
            end
            if (w_is_data && (r_state == S_DATA1)) begin
                r_d1 <= inByte[6:0];
            end
            r_index    <= w_index_next;
            r_gate     <= w_gate_next;
            r_velocity <= w_velocity_next;
            r_event    <= w_event_next;
        end
    end

    assign outMidiFrequencyIndex = r_index;
    assign outGate               = r_gate;
    assign outVelocity           = r_velocity;
    assign outNoteEvent          = r_event;

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Byte-level MIDI channel-voice parser that feeds the sample generator's note-index input.
- Takes received bytes from the UART receiver, one-cycle strobe per byte, and tracks status and running status.
- Decodes Note On / Note Off / CC123 (All Notes Off) on the selected channel.
- Drives a monophonic, last-note-priority note index, gate and velocity, all registered and stable between events.

Parameters:
- CHANNEL, 0: MIDI channel listened to (0..15, i.e. channels 1..16).
- OMNI, 0: 1 = accept voice messages on every channel and ignore CHANNEL.

Ports:
- inCLK  in  1  system clock
- inRST  in  1  reset; synchronous, active-high
- inByte  in  8  received MIDI byte; valid only when inByteValid=1
- inByteValid  in  1  one-cycle strobe, byte present; back-to-back strobes allowed
- outMidiFrequencyIndex  out  7  current note number (0..127), feeds sample generator
- outGate  out  1  1 while a note is held
- outVelocity  out  7  velocity of the current note
- outNoteEvent  out  1  one-cycle pulse whenever outMidiFrequencyIndex/outGate/outVelocity are updated

Behaviour:
- Reset (inRST high at posedge inCLK):
  - Outputs: outMidiFrequencyIndex=0, outGate=0, outVelocity=0, outNoteEvent=0.
  - Running status cleared, state=S_IDLE.
  - Reset has priority over a simultaneous inByteValid; a message interrupted mid-way by reset is discarded.
- Bytes are processed only on cycles with inByteValid=1. Otherwise all state holds and outNoteEvent=0.
- Byte classes:
  - Realtime 0xF8..0xFF: ignored entirely. State, running status and partially received data are untouched, even between data bytes.
  - System common 0xF0..0xF7: clears running status.
    - 0xF0 -> S_SKIP (SysEx).
    - 0xF7 and other F1..F6 -> S_IDLE. Their data bytes are dropped in S_IDLE.
  - Channel status 0x80..0xEF: latches status nibble and channel, stores a match flag (channel==CHANNEL or OMNI=1), -> S_DATA1. This aborts any incomplete message.
  - Data byte 0x00..0x7F: handled per state.
- States:
  - S_IDLE: data bytes ignored.
  - S_SKIP: data bytes ignored. Any status byte leaves as above.
  - S_DATA1: store data byte as d1.
    - Status Cx/Dx (1 data byte): message complete, -> S_DATA1 (running status).
    - Otherwise -> S_DATA2.
  - S_DATA2: d2=byte, message complete, -> S_DATA1 (running status).
- On message complete with match flag=1, updated registers are visible the cycle after the final data byte's strobe; outNoteEvent pulses in that same cycle:
  - 9x, d2!=0 (Note On): outMidiFrequencyIndex=d1, outVelocity=d2, outGate=1. This is last-note priority: replaces any held note.
  - 8x, or 9x with d2==0 (Note Off): only if outGate=1 and d1==outMidiFrequencyIndex, then outGate=0. Index and velocity are held so release keeps pitch. Non-matching Note Off gives no change and no pulse.
  - Bx with d1==123 (All Notes Off): outGate=0, pulse, regardless of d2. If outGate is already 0, still pulse.
  - All other messages, or match flag=0: consumed, no output change, no pulse.
- No buffering: the parser accepts a byte every cycle. Latency is exactly 1 cycle from final strobe to outputs.

Test Plan:
- Reset then 0x90,0x45,0x64 on consecutive cycles -> one cycle after the third strobe: index=69, velocity=100, gate=1, one-cycle outNoteEvent.
- Running status: 0x90,0x3C,0x40 then 0x40,0x50 -> second note: index=64, velocity=80, gate=1; two pulses total.
- Note Off mismatch/match: hold note 64, send 0x80,0x3C,0x00 -> no change, no pulse. Then 0x90,0x40,0x00 -> gate=0, index stays 64, one pulse.
- Realtime interleave and SysEx: 0x90,0xF8,0x30,0xFE,0x7F -> index=48, velocity=127. Then 0xF0,0x45,0x12,0xF7,0x50,0x50 -> no change (running status cleared).
- Channel filter with CHANNEL=2, OMNI=0: 0x91,0x40,0x40 -> no change. 0x92,0x40,0x40 -> note 64 gated. Then 0xB2,0x7B,0x00 -> gate=0 with pulse. Also 0xC2,0x05 followed by 0x07 -> consumed, no pulse.
- Reset mid-message: 0x90,0x45, then inRST high for one cycle, then 0x64 -> byte ignored (S_IDLE), outputs remain at reset values.
